reduction_nt1: RTL and testbench



---
 rtl/struct_s_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/unified_fifo.sv | 72 +++++++
 rtl/reduction_nt1.sv | 162 ++++++++++++++++
 tb/tb_reduction_nt1.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/struct_s_pkg.sv
// rtl/struct_s_pkg.sv - shared rule record, widths and reduction modes for the rule tree
package struct_s;

    localparam int unsigned RULE_ID_W  = 15;
    localparam int unsigned MAX_NUM_IN = 16;

    typedef struct packed {
        logic                 last;
        logic [RULE_ID_W-1:0] rule_id;
    } rule_s_t;

    localparam int unsigned RULE_S_WIDTH = $bits(rule_s_t);

    typedef enum logic [1:0] {
        MODE_DROP_ONLY = 2'd0,
        MODE_ARB       = 2'd1,
        MODE_SYNC      = 2'd2
    } red_mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant among requesting lanes, pointer moves past the winner
module rr_arbiter #(
    parameter  int unsigned DWIDTH = 4,
    localparam int unsigned IDX_W  = (DWIDTH > 1) ? $clog2(DWIDTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] i_req,
    input  logic              i_advance,
    output logic [IDX_W-1:0]  o_grant_idx,
    output logic              o_grant_valid
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W:0]   w_idx;

    // Search from the pointer upward with wrap; descending loop lets the nearest request win
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant_idx   = '0;
        w_idx         = '0;
        for (int k = DWIDTH - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_ptr} + (IDX_W + 1)'(k);
            if (w_idx >= (IDX_W + 1)'(DWIDTH)) begin
                w_idx = w_idx - (IDX_W + 1)'(DWIDTH);
            end
            if (i_req[w_idx[IDX_W-1:0]]) begin
                o_grant_valid = 1'b1;
                o_grant_idx   = w_idx[IDX_W-1:0];
            end
        end
    end

    // Pointer lands one past the winner only when the grant is actually consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance && o_grant_valid) begin
            r_ptr <= (o_grant_idx == IDX_W'(DWIDTH - 1)) ? '0 : o_grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/unified_fifo.sv
// rtl/unified_fifo.sv - single-clock show-ahead FIFO with almost-full that counts in-flight writes
module unified_fifo #(
    parameter  int unsigned DWIDTH     = 16,
    parameter  int unsigned DEPTH      = 32,
    parameter  int unsigned FULL_LEVEL = 20,
    parameter  string       MEM_TYPE   = "MLAB",
    localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW         = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [DWIDTH-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic              i_pending,
    output logic [DWIDTH-1:0] o_rd_data,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_almost_full
);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_wr_ok;
    logic              w_rd_ok;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty       = (r_count == '0);
    assign o_full        = (r_count == CW'(DEPTH));
    assign o_almost_full = ({1'b0, r_count} + (CW + 1)'(i_pending)) >= (CW + 1)'(FULL_LEVEL);
    assign w_wr_ok       = i_wr_en && !o_full;
    assign w_rd_ok       = i_rd_en && !o_empty;

    // Storage array carries no reset; only the pointers define what is valid
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_rd_ok) r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CW'(w_wr_ok) - CW'(w_rd_ok);
        end
    end

    if (MEM_TYPE == "MLAB") begin : g_lutram
        assign o_rd_data = r_mem[r_rd_ptr];
    end else begin : g_blockram
        logic [DWIDTH-1:0] r_head;
        logic [AW-1:0]     w_rd_ptr_n;
        assign w_rd_ptr_n = w_rd_ok ? ptr_inc(r_rd_ptr) : r_rd_ptr;
        // Registered head word, bypassing a write that lands on the next head slot
        always_ff @(posedge clk) begin
            r_head <= (w_wr_ok && (r_wr_ptr == w_rd_ptr_n)) ? i_wr_data : r_mem[w_rd_ptr_n];
        end
        assign o_rd_data = r_head;
    end

endmodule

// File: rtl/reduction_nt1.sv
// rtl/reduction_nt1.sv - N-to-1 rule reduction: per-lane dedup cache, merge, last sync, output FIFO
module reduction_nt1
    import struct_s::*;
#(
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned FIFO_DEPTH = 32,
    parameter int unsigned FULL_LEVEL = 20,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  rule_s_t [NUM_IN-1:0] in_data,
    input  logic    [NUM_IN-1:0] in_valid,
    output logic    [NUM_IN-1:0] in_ready,
    output rule_s_t              out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] stat_fwd,
    output logic [CNT_WIDTH-1:0] stat_drop,
    output logic                 overflow
);

    localparam int unsigned IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam int unsigned PC_W  = $clog2(NUM_IN + 1);

    rule_s_t [NUM_IN-1:0] r_cache;
    logic    [NUM_IN-1:0] r_cache_valid;
    rule_s_t              r_pipe_data;
    logic                 r_pipe_valid;
    logic [CNT_WIDTH-1:0] r_stat_fwd;
    logic [CNT_WIDTH-1:0] r_stat_drop;
    logic                 r_overflow;

    logic [NUM_IN-1:0]    w_cached;
    logic [NUM_IN-1:0]    w_cand;
    logic [NUM_IN-1:0]    w_merge;
    logic                 w_all_last;
    red_mode_e            w_mode;
    logic                 w_af;
    logic                 w_full;
    logic                 w_empty;
    logic [IDX_W-1:0]     w_grant_idx;
    logic                 w_grant_valid;
    rule_s_t              w_win;
    logic                 w_arb_go;
    logic                 w_sync_go;
    logic                 w_enq;
    rule_s_t              w_enq_data;
    logic [PC_W-1:0]      w_n_cached;
    logic [PC_W-1:0]      w_n_merge;
    logic [CNT_WIDTH-1:0] w_drop_inc;

    // Classify each lane: cache hit, fresh candidate, or parked on a last marker
    always_comb begin
        w_cached   = '0;
        w_cand     = '0;
        w_all_last = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            w_cached[i] = in_valid[i] && !in_data[i].last && r_cache_valid[i] &&
                          (in_data[i] == r_cache[i]);
            w_cand[i]   = in_valid[i] && !in_data[i].last && !w_cached[i];
            if (!(in_valid[i] && in_data[i].last)) w_all_last = 1'b0;
        end
    end

    rr_arbiter #(
        .DWIDTH (NUM_IN)
    ) u_arb (
        .clk           (clk),
        .rst           (rst),
        .i_req         (w_cand),
        .i_advance     (w_arb_go),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    assign w_win = in_data[w_grant_idx];

    // Mode select, merge vector, pops, enqueue request and drop accounting
    always_comb begin
        w_mode = MODE_DROP_ONLY;
        if (w_all_last)   w_mode = MODE_SYNC;
        else if (|w_cand) w_mode = MODE_ARB;

        w_sync_go = (w_mode == MODE_SYNC) && !w_af;
        w_arb_go  = (w_mode == MODE_ARB) && w_grant_valid && !w_af;

        w_merge    = '0;
        w_n_cached = '0;
        w_n_merge  = '0;
        for (int j = 0; j < NUM_IN; j++) begin
            w_merge[j] = w_cand[j] && (in_data[j] == w_win);
            w_n_cached = w_n_cached + PC_W'(w_cached[j]);
            w_n_merge  = w_n_merge + PC_W'(w_merge[j]);
        end

        if (rst)            in_ready = '0;
        else if (w_sync_go) in_ready = '1;
        else                in_ready = w_cached | (w_arb_go ? w_merge : '0);

        w_enq      = w_sync_go || w_arb_go;
        w_enq_data = w_sync_go ? in_data[0] : w_win;

        w_drop_inc = CNT_WIDTH'(w_n_cached);
        if (w_arb_go)  w_drop_inc = w_drop_inc + CNT_WIDTH'(w_n_merge) - CNT_WIDTH'(1);
        if (w_sync_go) w_drop_inc = w_drop_inc + CNT_WIDTH'(NUM_IN - 1);
    end

    // Pipeline stage, lane caches, statistics and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cache       <= '0;
            r_cache_valid <= '0;
            r_pipe_data   <= '0;
            r_pipe_valid  <= 1'b0;
            r_stat_fwd    <= '0;
            r_stat_drop   <= '0;
            r_overflow    <= 1'b0;
        end else begin
            r_pipe_valid <= w_enq;
            r_pipe_data  <= w_enq_data;
            if (w_enq) r_stat_fwd <= r_stat_fwd + 1'b1;
            r_stat_drop <= r_stat_drop + w_drop_inc;
            if (r_pipe_valid && w_full) r_overflow <= 1'b1;
            if (w_sync_go) begin
                r_cache       <= '0;
                r_cache_valid <= '0;
            end else if (w_arb_go) begin
                for (int j = 0; j < NUM_IN; j++) begin
                    if (w_merge[j]) begin
                        r_cache[j]       <= w_win;
                        r_cache_valid[j] <= 1'b1;
                    end
                end
            end
        end
    end

    unified_fifo #(
        .DWIDTH     (RULE_S_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .FULL_LEVEL (FULL_LEVEL),
        .MEM_TYPE   ("MLAB")
    ) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .i_wr_en       (r_pipe_valid),
        .i_wr_data     (r_pipe_data),
        .i_rd_en       (out_ready),
        .i_pending     (r_pipe_valid),
        .o_rd_data     (out_data),
        .o_empty       (w_empty),
        .o_full        (w_full),
        .o_almost_full (w_af)
    );

    assign out_valid = !w_empty;
    assign stat_fwd  = r_stat_fwd;
    assign stat_drop = r_stat_drop;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_reduction_nt1.sv
// tb/tb_reduction_nt1.sv - directed scoreboard bench for reduction_nt1
module tb_reduction_nt1;
    import struct_s::*;

    localparam int NI = 4;

    logic              clk = 1'b0;
    logic              rst;
    rule_s_t [NI-1:0]  in_data;
    logic    [NI-1:0]  in_valid;
    logic    [NI-1:0]  in_ready;
    rule_s_t           out_data;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       stat_fwd;
    logic [31:0]       stat_drop;
    logic              overflow;

    rule_s_t     lane_q [NI][$];
    rule_s_t     sb [$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [NI-1:0] popped;
    logic [31:0] exp_fwd  = 0;
    logic [31:0] exp_drop = 0;

    reduction_nt1 #(
        .NUM_IN     (NI),
        .FIFO_DEPTH (32),
        .FULL_LEVEL (20),
        .CNT_WIDTH  (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .stat_fwd  (stat_fwd),
        .stat_drop (stat_drop),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic rule_s_t mk(input int id);
        rule_s_t r;
        r.last    = 1'b0;
        r.rule_id = id[14:0];
        return r;
    endfunction

    function automatic rule_s_t mk_last();
        rule_s_t r;
        r.last    = 1'b1;
        r.rule_id = '0;
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic bit lanes_busy();
        for (int i = 0; i < NI; i++) if (lane_q[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // One cycle: present queue heads, sample handshakes mid-cycle, retire popped heads
    task automatic tick();
        for (int i = 0; i < NI; i++) begin
            if (lane_q[i].size() != 0) begin
                in_valid[i] = 1'b1;
                in_data[i]  = lane_q[i][0];
            end else begin
                in_valid[i] = 1'b0;
                in_data[i]  = '0;
            end
        end
        @(negedge clk);
        popped = in_ready & in_valid;
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) if (popped[i]) void'(lane_q[i].pop_front());
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while ((lanes_busy() || sb.size() != 0) && n < max_cycles) begin
            tick();
            n++;
        end
        check("drain_done", {63'd0, (lanes_busy() || sb.size() != 0)}, 64'd0);
        repeat (2) tick();
    endtask

    task automatic check_stats(input string tag);
        check({tag, "_fwd"}, stat_fwd, exp_fwd);
        check({tag, "_drop"}, stat_drop, exp_drop);
    endtask

    // Output side of the scoreboard: every accepted beat must match the oldest expectation
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_assert++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_output observed=0x%0h expected=none", out_data);
            end
            if (sb.size() != 0) check("out_data", out_data, sb.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        in_valid = '1;
        for (int i = 0; i < NI; i++) in_data[i] = mk(5);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = '0;
        in_data  = '0;
        check("rst_out_valid", out_valid, 0);
        check("rst_overflow", overflow, 0);
        check_stats("rst");

        // Four distinct rules at once: round-robin from lane 0
        for (int i = 0; i < NI; i++) begin
            lane_q[i].push_back(mk(32'h11 * (i + 1)));
            sb.push_back(mk(32'h11 * (i + 1)));
        end
        exp_fwd += 4;
        drain(40);
        check_stats("rr4");

        // Lanes 0,2,3 carry the same rule and merge into one output
        lane_q[0].push_back(mk('h55));
        lane_q[1].push_back(mk('h66));
        lane_q[2].push_back(mk('h55));
        lane_q[3].push_back(mk('h55));
        sb.push_back(mk('h55));
        sb.push_back(mk('h66));
        tick();
        check("merge_pop", popped, 4'b1101);
        exp_fwd  += 2;
        exp_drop += 2;
        drain(40);
        check_stats("merge");

        // Repeat on lane 1 is a cache hit; first pop shows at the output two cycles later
        lane_q[1].push_back(mk('h77));
        lane_q[1].push_back(mk('h77));
        sb.push_back(mk('h77));
        tick();
        check("first_pop", popped, 4'b0010);
        check("latency_t1", out_valid, 0);
        tick();
        check("cache_hit_pop", popped, 4'b0010);
        check("latency_t2", out_valid, 1);
        exp_fwd  += 1;
        exp_drop += 1;
        drain(40);
        check_stats("cache");

        // Last markers wait until every lane holds one, then collapse into a single marker
        for (int i = 0; i < 3; i++) lane_q[i].push_back(mk_last());
        lane_q[3].push_back(mk('h88));
        lane_q[3].push_back(mk_last());
        sb.push_back(mk('h88));
        sb.push_back(mk_last());
        tick();
        check("last_wait", popped, 4'b1000);
        tick();
        check("sync_pop", popped, 4'b1111);
        drain(40);
        lane_q[3].push_back(mk('h88));
        sb.push_back(mk('h88));
        drain(40);
        exp_fwd  += 3;
        exp_drop += 3;
        check_stats("sync");

        // Backpressure: candidates stall at fill 20 while cache hits keep draining
        lane_q[1].push_back(mk('hA0));
        sb.push_back(mk('hA0));
        drain(40);
        exp_fwd += 1;
        out_ready = 1'b0;
        for (int k = 0; k < 30; k++) begin
            lane_q[0].push_back(mk('h100 + k));
            sb.push_back(mk('h100 + k));
        end
        for (int k = 0; k < 40; k++) lane_q[1].push_back(mk('hA0));
        repeat (25) tick();
        check("bp_ready", popped, 4'b0010);
        repeat (25) tick();
        check("bp_lane0_left", lane_q[0].size(), 10);
        check("bp_lane1_left", lane_q[1].size(), 0);
        check("bp_overflow", overflow, 0);
        out_ready = 1'b1;
        drain(200);
        exp_fwd  += 30;
        exp_drop += 40;
        check_stats("bp");
        check("bp_overflow_end", overflow, 0);

        // Reset with entries queued discards them and forgets the caches
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            lane_q[0].push_back(mk('h200 + k));
            sb.push_back(mk('h200 + k));
        end
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        exp_fwd  = 0;
        exp_drop = 0;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_overflow", overflow, 0);
        check_stats("mid_rst");
        out_ready = 1'b1;
        lane_q[0].push_back(mk('h204));
        sb.push_back(mk('h204));
        exp_fwd += 1;
        drain(40);
        check_stats("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
